// File: rtl/fpu_in2_gt_in1_seq_pkg.sv
// Package shared by the sequential din2 > din1 comparator.
// Contents:
//   state_t        FSM encoding (IDLE=0, SCAN=1, DONE=2)
//   calc_nchunk()  number of CHUNK-bit slices needed to cover WIDTH bits
//   calc_padded()  zero-padded operand width (NCHUNK*CHUNK)
//   calc_idx_w()   width of the slice index counter (at least 1 bit)
package fpu_in2_gt_in1_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  function automatic int calc_padded(input int width, input int chunk);
    return calc_nchunk(width, chunk) * chunk;
  endfunction

  // A single slice still needs a 1-bit index so the counter never collapses
  // to zero width.
  function automatic int calc_idx_w(input int width, input int chunk);
    int n;
    n = calc_nchunk(width, chunk);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_in2_gt_in1_seq_if.sv
// Handshake/data bundle for fpu_in2_gt_in1_seq.
// Ports carried:
//   in_vld/in_rdy        operand handshake
//   din1/din2            WIDTH-bit operands
//   cmp_signed           1 = two's-complement compare, sampled with operands
//   abort                synchronous cancel
//   out_vld/out_rdy      result handshake
//   din2_neq_din1        din2 != din1
//   din2_gt_din1         din2 > din1 under the sampled mode
//   busy                 comparator not idle
// master = operand producer / result consumer, slave = comparator.
interface fpu_in2_gt_in1_seq_if #(
  parameter int WIDTH = 64
);
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic             cmp_signed;
  logic             abort;
  logic             out_vld;
  logic             out_rdy;
  logic             din2_neq_din1;
  logic             din2_gt_din1;
  logic             busy;

  modport master (
    output in_vld, din1, din2, cmp_signed, abort, out_rdy,
    input  in_rdy, out_vld, din2_neq_din1, din2_gt_din1, busy
  );

  modport slave (
    input  in_vld, din1, din2, cmp_signed, abort, out_rdy,
    output in_rdy, out_vld, din2_neq_din1, din2_gt_din1, busy
  );
endinterface

// File: rtl/fpu_in2_gt_in1_chunk.sv
// Combinational single-slice comparator.
// Ports:
//   slice1  in  CHUNK  slice of operand 1
//   slice2  in  CHUNK  slice of operand 2
//   neq     out 1      slices differ
//   gt      out 1      slice2 > slice1 (unsigned)
module fpu_in2_gt_in1_chunk #(
  parameter int CHUNK = 3
) (
  input  logic [CHUNK-1:0] slice1,
  input  logic [CHUNK-1:0] slice2,
  output logic             neq,
  output logic             gt
);

  assign neq = (slice1 != slice2);
  assign gt  = (slice2 > slice1);

endmodule

// File: rtl/fpu_in2_gt_in1_seq.sv
// Multi-cycle magnitude comparator: scans the operands CHUNK bits per cycle
// from the most significant slice down and stops at the first slice that
// differs. Signed compares reuse the unsigned datapath by inverting bit
// WIDTH-1 of both operands at load time.
// Ports:
//   rclk    in   clock
//   arst_l  in   asynchronous active-low reset
//   bus     slave modport of fpu_in2_gt_in1_seq_if (handshakes, operands,
//           mode, abort, results, busy)
module fpu_in2_gt_in1_seq
  import fpu_in2_gt_in1_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 3
) (
  input  logic                   rclk,
  input  logic                   arst_l,
  fpu_in2_gt_in1_seq_if.slave    bus
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int PW     = calc_padded(WIDTH, CHUNK);
  localparam int IDX_W  = calc_idx_w(WIDTH, CHUNK);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [PW-1:0]    op1_reg;
  logic [PW-1:0]    op2_reg;
  logic             out_vld_reg;
  logic             neq_reg;
  logic             gt_reg;
  logic             busy_reg;

  logic             in_rdy_int;
  logic             accept;

  logic [CHUNK-1:0] slices1 [NCHUNK];
  logic [CHUNK-1:0] slices2 [NCHUNK];
  logic [CHUNK-1:0] sel1;
  logic [CHUNK-1:0] sel2;
  logic             slice_neq;
  logic             slice_gt;

  // Zero-extend to the padded width, then flip the true sign bit (not the
  // padded MSB) so that an unsigned compare gives the two's-complement order.
  function automatic logic [PW-1:0] load_op(input logic [WIDTH-1:0] d,
                                            input logic sgn);
    logic [PW-1:0] p;
    p = PW'(d);
    p[WIDTH-1] = p[WIDTH-1] ^ sgn;
    return p;
  endfunction

  // Ready is combinational so a result handshake and a new accept can share
  // a cycle. Abort always blocks a new accept; reset forces it low.
  always_comb begin
    in_rdy_int = 1'b0;
    case (state_reg)
      ST_IDLE: in_rdy_int = ~bus.abort;
      ST_DONE: in_rdy_int = bus.out_rdy & ~bus.abort;
      default: in_rdy_int = 1'b0;
    endcase
    in_rdy_int = in_rdy_int & arst_l;
  end

  assign accept = bus.in_vld & in_rdy_int;

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign slices1[gi] = op1_reg[gi*CHUNK +: CHUNK];
      assign slices2[gi] = op2_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // Explicit compare-select mux: the index counter can encode values beyond
  // NCHUNK-1 when NCHUNK is not a power of two, so no direct array index.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        sel1 = slices1[i];
        sel2 = slices2[i];
      end
    end
  end

  fpu_in2_gt_in1_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .slice1 (sel1),
    .slice2 (sel2),
    .neq    (slice_neq),
    .gt     (slice_gt)
  );

  // Operand registers only move on an accepted handshake.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      op1_reg <= '0;
      op2_reg <= '0;
    end else if (accept) begin
      op1_reg <= load_op(bus.din1, bus.cmp_signed);
      op2_reg <= load_op(bus.din2, bus.cmp_signed);
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      out_vld_reg <= 1'b0;
      neq_reg     <= 1'b0;
      gt_reg      <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            idx_reg   <= IDX_LAST;
            state_reg <= ST_SCAN;
            busy_reg  <= 1'b1;
          end
        end

        ST_SCAN: begin
          if (bus.abort) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else if (slice_neq) begin
            state_reg   <= ST_DONE;
            out_vld_reg <= 1'b1;
            neq_reg     <= 1'b1;
            gt_reg      <= slice_gt;
          end else if (idx_reg == '0) begin
            state_reg   <= ST_DONE;
            out_vld_reg <= 1'b1;
            neq_reg     <= 1'b0;
            gt_reg      <= 1'b0;
          end else begin
            idx_reg <= idx_reg - IDX_W'(1);
          end
        end

        ST_DONE: begin
          if (bus.out_rdy) begin
            // Transfer completes even with abort; abort only blocks the
            // follow-on accept through in_rdy.
            out_vld_reg <= 1'b0;
            if (accept) begin
              idx_reg   <= IDX_LAST;
              state_reg <= ST_SCAN;
            end else begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end else if (bus.abort) begin
            out_vld_reg <= 1'b0;
            state_reg   <= ST_IDLE;
            busy_reg    <= 1'b0;
          end
        end

        default: begin
          state_reg   <= ST_IDLE;
          out_vld_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_rdy        = in_rdy_int;
  assign bus.out_vld       = out_vld_reg;
  assign bus.din2_neq_din1 = neq_reg;
  assign bus.din2_gt_din1  = gt_reg;
  assign bus.busy          = busy_reg;

endmodule

// File: tb/tb_fpu_in2_gt_in1_seq.sv
// Scoreboard bench for fpu_in2_gt_in1_seq (WIDTH=64, CHUNK=3, NCHUNK=22).
// Accepted operands are turned into expected results by a reference model
// using plain signed/unsigned arithmetic; a monitor pops and compares at each
// result handshake, including the latency from accept to out_vld.
module tb_fpu_in2_gt_in1_seq;

  localparam int WIDTH  = 64;
  localparam int CHUNK  = 3;
  localparam int NCHUNK = 22;
  localparam logic [63:0] MSB = 64'h8000_0000_0000_0000;

  typedef struct {
    logic        neq;
    logic        gt;
    int          lat;
    int          acc;
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic arst_l = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  bit   rdy_rand = 1'b0;
  exp_t sb_q[$];

  fpu_in2_gt_in1_seq_if #(.WIDTH(WIDTH)) bus ();

  fpu_in2_gt_in1_seq #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .rclk   (clk),
    .arst_l (arst_l),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference: result from the arithmetic meaning of the operands; latency
  // from the position of the highest differing bit (2 + equal leading slices).
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic sgn, input int acc);
    exp_t e;
    logic [63:0] x;
    int p;
    e.a = a;
    e.b = b;
    e.acc = acc;
    e.neq = (a != b);
    e.gt  = sgn ? ($signed(b) > $signed(a)) : (b > a);
    x = a ^ b;
    p = -1;
    for (int i = 63; i >= 0; i--) begin
      if (p < 0 && x[i]) p = i;
    end
    e.lat = (p < 0) ? (2 + NCHUNK - 1) : (2 + (NCHUNK - 1 - p / CHUNK));
    return e;
  endfunction

  // Accept observer: handshake seen here is registered at the next edge.
  always @(negedge clk) begin
    if (arst_l && bus.in_vld && bus.in_rdy)
      sb_q.push_back(model(bus.din1, bus.din2, bus.cmp_signed, cyc));
  end

  // Result monitor.
  bit   have_vld = 1'b0;
  int   vld_cyc = 0;
  logic held_neq, held_gt;
  always @(negedge clk) begin
    exp_t e;
    if (!arst_l) begin
      have_vld = 1'b0;
    end else if (bus.out_vld) begin
      if (!have_vld) begin
        have_vld = 1'b1;
        vld_cyc  = cyc;
        held_neq = bus.din2_neq_din1;
        held_gt  = bus.din2_gt_din1;
      end else begin
        chk("hold_neq", bus.din2_neq_din1, held_neq);
        chk("hold_gt", bus.din2_gt_din1, held_gt);
      end
      if (bus.out_rdy) begin
        if (sb_q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          e = sb_q.pop_front();
          txn++;
          $display("txn %0d: din1=%h din2=%h neq=%0b gt=%0b latency=%0d (exp %0b %0b %0d)",
                   txn, e.a, e.b, bus.din2_neq_din1, bus.din2_gt_din1,
                   vld_cyc - e.acc, e.neq, e.gt, e.lat);
          chk("neq", bus.din2_neq_din1, e.neq);
          chk("gt", bus.din2_gt_din1, e.gt);
          chk("latency", 64'(vld_cyc - e.acc), 64'(e.lat));
        end
        have_vld = 1'b0;
      end
    end else begin
      have_vld = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      bus.out_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sgn);
    bit ok;
    @(posedge clk);
    #1;
    bus.in_vld = 1'b1;
    bus.din1 = a;
    bus.din2 = b;
    bus.cmp_signed = sgn;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_rdy;
    end
    if (!ok) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = (sb_q.size() == 0) && !bus.out_vld && !bus.busy;
    end
    if (!ok) begin
      fail_now("drain_timeout");
      sb_q.delete();
    end
  endtask

  task automatic wait_vld();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = bus.out_vld;
    end
    if (!ok) fail_now("out_vld_timeout");
  endtask

  initial begin
    logic [63:0] a, b;
    bit seen;
    bus.in_vld = 1'b0;
    bus.din1 = '0;
    bus.din2 = '0;
    bus.cmp_signed = 1'b0;
    bus.abort = 1'b0;
    bus.out_rdy = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_neq", bus.din2_neq_din1, 0);
    chk("rst_gt", bus.din2_gt_din1, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_rdy", bus.in_rdy, 0);
    @(posedge clk);
    #1 arst_l = 1'b1;
    @(negedge clk);
    chk("post_rst_in_rdy", bus.in_rdy, 1);
    chk("post_rst_busy", bus.busy, 0);

    // Directed: MSB difference, signed flip, equal, low slices
    issue(64'h0, MSB, 1'b0);                 wait_idle();
    issue(64'h0, MSB, 1'b1);                 wait_idle();
    issue(64'h1234, 64'h1234, 1'b0);         wait_idle();
    issue(64'd5, 64'd6, 1'b0);               wait_idle();
    issue(64'd8, 64'd7, 1'b0);               wait_idle();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1); wait_idle();

    // Backpressure then back-to-back accept in the handshake cycle
    bus.out_rdy = 1'b0;
    issue(64'd3, MSB | 64'd3, 1'b0);
    wait_vld();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_rdy", bus.in_rdy, 0);
      chk("bp_out_vld", bus.out_vld, 1);
    end
    @(posedge clk);
    #1;
    bus.out_rdy = 1'b1;
    bus.in_vld = 1'b1;
    bus.din1 = 64'd100;
    bus.din2 = 64'd99;
    bus.cmp_signed = 1'b0;
    @(negedge clk);
    chk("b2b_in_rdy", bus.in_rdy, 1);
    @(posedge clk);
    #1 bus.in_vld = 1'b0;
    @(negedge clk);
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_out_vld", bus.out_vld, 0);
    wait_idle();

    // Abort in IDLE only blocks ready
    @(posedge clk);
    #1 bus.abort = 1'b1;
    @(negedge clk);
    chk("idle_abort_in_rdy", bus.in_rdy, 0);
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_busy", bus.busy, 0);

    // Abort during SCAN of an all-equal compare, sampled at T+5
    issue(64'h1234, 64'h1234, 1'b0);
    repeat (3) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(negedge clk);
    sb_q.delete();
    chk("scan_abort_in_rdy", bus.in_rdy, 0);
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("scan_abort_busy", bus.busy, 0);
    chk("scan_abort_in_rdy_after", bus.in_rdy, 1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_vld) seen = 1'b1;
    end
    chk("scan_abort_no_result", seen, 0);

    // Abort in DONE without out_rdy drops the result
    bus.out_rdy = 1'b0;
    issue(64'h0, MSB, 1'b0);
    wait_vld();
    @(posedge clk);
    #1 bus.abort = 1'b1;
    @(negedge clk);
    sb_q.delete();
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("done_abort_out_vld", bus.out_vld, 0);
    chk("done_abort_busy", bus.busy, 0);
    chk("done_abort_neq_kept", bus.din2_neq_din1, 1);

    // Abort with result handshake: transfer completes, new accept blocked
    issue(64'd10, 64'd20, 1'b0);
    wait_vld();
    @(posedge clk);
    #1;
    bus.out_rdy = 1'b1;
    bus.abort = 1'b1;
    bus.in_vld = 1'b1;
    bus.din1 = 64'd1;
    bus.din2 = 64'd2;
    @(negedge clk);
    chk("abort_hs_in_rdy", bus.in_rdy, 0);
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    bus.in_vld = 1'b0;
    @(negedge clk);
    chk("abort_hs_busy", bus.busy, 0);
    chk("abort_hs_out_vld", bus.out_vld, 0);
    wait_idle();

    // Asynchronous reset mid-SCAN, with neq/gt left at 1 by the last result
    issue(64'h1234, 64'h1234, 1'b0);
    repeat (2) @(posedge clk);
    #2 arst_l = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_out_vld", bus.out_vld, 0);
    chk("arst_neq", bus.din2_neq_din1, 0);
    chk("arst_gt", bus.din2_gt_din1, 0);
    chk("arst_in_rdy", bus.in_rdy, 0);
    sb_q.delete();
    @(posedge clk);
    #1 arst_l = 1'b1;
    issue(64'd7, 64'd9, 1'b0);
    wait_idle();

    // Randomized operands, modes, gaps and backpressure
    rdy_rand = 1'b1;
    for (int n = 0; n < 200; n++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = {$urandom, $urandom};
        1: b = a;
        2: b = a ^ (64'd1 << $urandom_range(0, 63));
        default: begin
          a = 64'($urandom_range(0, 63));
          b = 64'($urandom_range(0, 63));
        end
      endcase
      issue(a, b, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rdy_rand = 1'b0;
    @(posedge clk);
    #2 bus.out_rdy = 1'b1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fpu_in2_gt_in1_seq.md
Name: fpu_in2_gt_in1_seq

Overview:
Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands CHUNK bits per cycle, scanning from the MSB chunk down, and stops at the first chunk that differs. It generalises the fixed 3-chunk neq/gt reduction to any width, and adds signed mode, valid/ready handshakes and abort. It serves FPU paths where compare latency is not critical and area matters, such as exponent/mantissa compare in iterative units.

Parameters:
WIDTH, 64, operand width in bits (>=2)
CHUNK, 3, bits compared per cycle (1..WIDTH)
NCHUNK, derived ceil(WIDTH/CHUNK), number of slices; operands zero-extended to NCHUNK*CHUNK bits

Ports:
rclk  in  1  clock
arst_l  in  1  asynchronous active-low reset
in_vld  in  1  operand valid
in_rdy  out  1  block accepts operands
din1  in  WIDTH  operand 1
din2  in  WIDTH  operand 2
cmp_signed  in  1  1 = two's-complement compare, 0 = unsigned; sampled with operands
abort  in  1  synchronous cancel of the current operation
out_vld  out  1  result valid
out_rdy  in  1  consumer takes result
din2_neq_din1  out  1  din2 != din1
din2_gt_din1  out  1  din2 > din1 (under sampled mode)
busy  out  1  state != IDLE

Behaviour:
- One clock, rclk. Reset is asynchronous and active-low on arst_l.
- Reset values: state=IDLE, out_vld=0, din2_neq_din1=0, din2_gt_din1=0, busy=0, chunk index=0. in_rdy=1 once reset deasserts.
- States:
  - IDLE: in_rdy=1.
  - SCAN: in_rdy=0.
  - DONE: out_vld=1; in_rdy=out_rdy.
- Accept: in_vld&in_rdy at cycle T.
  - Latch din1/din2, zero-extended to NCHUNK*CHUNK bits.
  - If cmp_signed, invert bit WIDTH-1 of both latched operands (sign-flip trick).
  - Set idx=NCHUNK-1 and go to SCAN.
- SCAN, each cycle: compare slice idx of each operand.
  - If the slices differ: go to DONE, neq=1, gt=(slice2>slice1).
  - Else if idx==0: go to DONE, neq=0, gt=0.
  - Else: idx-1.
- Latency: out_vld rises at T+2+k, where k = number of equal leading slices (0..NCHUNK-1). Worst case is T+1+NCHUNK.
- DONE: results and out_vld are held stable until out_vld&out_rdy.
  - On handshake: go to IDLE, or straight back to SCAN if a new accept occurs in the same cycle (back-to-back, no bubble).
  - Result registers update only when entering DONE.
- abort=1 in SCAN: go to IDLE next cycle; no result is produced; in_rdy=0 during the abort cycle.
- abort=1 in DONE without out_rdy: drop the result, out_vld=0 next cycle.
- abort together with out_vld&out_rdy: the transfer completes. Go to IDLE; a simultaneous new accept is blocked because in_rdy is forced to 0 by abort.
- abort in IDLE: no effect other than in_rdy=0 for that cycle.
- arst_l asserted mid-SCAN or in DONE: immediate return to reset values; any in-flight result is lost.
- Operand registers do not change outside an accept.
- Padding bits are always 0. The sign flip applies to bit WIDTH-1, not to the padded MSB.

Decomposition:
- Shared include: state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2), and the NCHUNK / padded-width localparam function.
- One combinational sub-module, fpu_in2_gt_in1_chunk, parametrised on CHUNK: takes two slices, returns neq and gt.
- This block holds the FSM, the index counter, the operand registers and the slice mux.

Test Plan (WIDTH=64, CHUNK=3, NCHUNK=22):
1. Unsigned MSB difference: din1=0, din2=64'h8000_0000_0000_0000, cmp_signed=0, accept at T -> out_vld at T+2, neq=1, gt=1.
2. Signed, same operands as 1 with cmp_signed=1 -> out_vld at T+2, neq=1, gt=0 (din2 negative).
3. Equal operands: din1=din2=64'h1234 -> out_vld at T+23, neq=0, gt=0.
4. Low-slice differences:
   - din1=5, din2=6 (slice 0 differs) -> T+23, neq=1, gt=1.
   - din1=8, din2=7 (slice 1 differs) -> T+22, neq=1, gt=0.
5. Backpressure and back-to-back:
   - Hold out_rdy=0 for 5 cycles -> outputs stable, in_rdy=0.
   - Then out_rdy=1 with in_vld=1 -> new operands accepted in the same cycle, next result correct.
6. Abort and reset:
   - abort at T+5 during case 3 -> IDLE at T+6, out_vld never rises, in_rdy=1 at T+6.
   - Separately, arst_l low at T+4 -> all outputs 0 immediately; a fresh accept after release works normally.
